// File: rtl/cpu6_memstage_lsu.sv
// MEM-stage load/store unit: turns the MEM access into a bus request/response
// handshake, stalls the pipeline until it completes, and owns the MEM/WB register.
module cpu6_memstage_lsu #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memwriteM,
  input  logic                   memtoregM,
  input  logic [1:0]             memsizeM,
  input  logic                   memunsignedM,
  input  logic [XLEN-1:0]        aluoutM,
  input  logic [XLEN-1:0]        writedataM,
  input  logic [RFIDX_WIDTH-1:0] writeregM,
  input  logic                   regwriteM,
  input  logic                   jumpM,
  input  logic [XLEN-1:0]        pcplus4M,
  output logic                   stallM,
  output logic                   misalignM,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic                   req_we,
  output logic [XLEN-1:0]        req_addr,
  output logic [3:0]             req_be,
  output logic [XLEN-1:0]        req_wdata,
  input  logic                   resp_valid,
  input  logic [XLEN-1:0]        resp_rdata,
  output logic [XLEN-1:0]        resultW,
  output logic [RFIDX_WIDTH-1:0] writeregW,
  output logic                   regwriteW
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                  state_q, state_d;
  logic [XLEN-1:0]         result_q, result_d;
  logic [RFIDX_WIDTH-1:0]  wreg_q, wreg_d;
  logic                    rw_q, rw_d;

  logic [1:0]              a;
  logic                    acc, is_half, is_word, misaligned, go;
  logic [XLEN-1:0]         load_data;

  function automatic logic [3:0] f_byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   f_byte_en = 4'b0001 << off;
      2'b01:   f_byte_en = 4'b0011 << off;
      default: f_byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] f_replicate(input logic [1:0] size, input logic [XLEN-1:0] wd);
    case (size)
      2'b00:   f_replicate = {4{wd[7:0]}};
      2'b01:   f_replicate = {2{wd[15:0]}};
      default: f_replicate = wd;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] f_load_ext(input logic [1:0] size, input logic uns,
                                                 input logic [XLEN-1:0] rdata, input logic [1:0] off);
    logic [XLEN-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'b00:   f_load_ext = {{(XLEN-8){~uns & sh[7]}}, sh[7:0]};
      2'b01:   f_load_ext = {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
      default: f_load_ext = sh;
    endcase
  endfunction

  assign a          = aluoutM[1:0];
  assign acc        = memwriteM | memtoregM;
  assign is_half    = (memsizeM == 2'b01);
  assign is_word    = memsizeM[1];
  assign misaligned = acc & ((is_half & a[0]) | (is_word & (a != 2'b00)));
  assign go         = acc & ~misaligned;
  assign misalignM  = misaligned;

  // Bus fields come straight from the MEM inputs; stallM keeps those frozen while in REQ.
  assign req_we    = memwriteM;
  assign req_addr  = {aluoutM[XLEN-1:2], 2'b00};
  assign req_be    = f_byte_en(memsizeM, a);
  assign req_wdata = f_replicate(memsizeM, writedataM);
  assign load_data = f_load_ext(memsizeM, memunsignedM, resp_rdata, a);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = req_ready ? S_WAIT : S_REQ;
      S_REQ:   if (req_ready) state_d = S_WAIT;
      S_WAIT:  if (resp_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_valid = 1'b0;
    case (state_q)
      S_IDLE:  req_valid = go & ~reset;
      S_REQ:   req_valid = ~reset;
      default: req_valid = 1'b0;
    endcase
    stallM = go & ~((state_q == S_WAIT) & resp_valid);
  end

  // MEM/WB boundary: capture the result when not stalled, otherwise insert a bubble.
  always_comb begin
    result_d = '0;
    wreg_d   = '0;
    rw_d     = 1'b0;
    if (!stallM) begin
      if (jumpM)                        result_d = pcplus4M;
      else if (memtoregM && !memwriteM) result_d = load_data;
      else                              result_d = aluoutM;
      wreg_d = writeregM;
      rw_d   = regwriteM & ~misaligned;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      wreg_q   <= '0;
      rw_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      wreg_q   <= wreg_d;
      rw_q     <= rw_d;
    end
  end

  assign resultW   = result_q;
  assign writeregW = wreg_q;
  assign regwriteW = rw_q;

endmodule

// File: tb/tb_cpu6_memstage_lsu.sv
// Bench for cpu6_memstage_lsu: directed instructions, with WB results and bus requests
// checked by a scoreboard monitor.
module tb_cpu6_memstage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwriteM, memtoregM, memunsignedM, regwriteM, jumpM;
  logic [1:0]  memsizeM;
  logic [31:0] aluoutM, writedataM, pcplus4M;
  logic [4:0]  writeregM;
  logic        stallM, misalignM, req_valid, req_ready, req_we, resp_valid;
  logic [31:0] req_addr, req_wdata, resp_rdata, resultW;
  logic [3:0]  req_be;
  logic [4:0]  writeregW;
  logic        regwriteW;

  cpu6_memstage_lsu #(.XLEN(32), .RFIDX_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .memwriteM(memwriteM), .memtoregM(memtoregM),
    .memsizeM(memsizeM), .memunsignedM(memunsignedM), .aluoutM(aluoutM),
    .writedataM(writedataM), .writeregM(writeregM), .regwriteM(regwriteM),
    .jumpM(jumpM), .pcplus4M(pcplus4M), .stallM(stallM), .misalignM(misalignM),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resultW(resultW),
    .writeregW(writeregW), .regwriteW(regwriteW)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] res; logic [4:0] wreg; logic rw; } wb_t;
  typedef struct packed { logic [31:0] addr; logic [3:0] be; logic [31:0] wd; logic we; } rq_t;

  wb_t wbq[$];
  rq_t rqq[$];
  int  total = 0;
  int  bad = 0;
  int  wb_seen = 0;
  int  wb_exp = 0;
  logic tb_instr = 1'b0;
  logic pending = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: WB register after each captured instruction, bus request at each handshake.
  always @(negedge clk) begin
    wb_t e;
    rq_t r;
    if (pending) begin
      if (wbq.size() == 0) chk("wb_queue_underflow", 64'd1, 64'd0);
      else begin
        e = wbq.pop_front();
        chk("wb_result", {32'd0, resultW}, {32'd0, e.res});
        chk("wb_wreg", {59'd0, writeregW}, {59'd0, e.wreg});
        chk("wb_regwrite", {63'd0, regwriteW}, {63'd0, e.rw});
        if (regwriteW) wb_seen++;
      end
    end else if (regwriteW) begin
      chk("unexpected_wb_write", {63'd0, regwriteW}, 64'd0);
    end
    pending = tb_instr && !stallM && !reset;
    if (req_valid && req_ready && !reset) begin
      if (rqq.size() == 0) chk("req_queue_underflow", 64'd1, 64'd0);
      else begin
        r = rqq.pop_front();
        chk("req_addr", {32'd0, req_addr}, {32'd0, r.addr});
        chk("req_be", {60'd0, req_be}, {60'd0, r.be});
        chk("req_wdata", {32'd0, req_wdata}, {32'd0, r.wd});
        chk("req_we", {63'd0, req_we}, {63'd0, r.we});
      end
    end
  end

  task automatic nop();
    memwriteM = 0; memtoregM = 0; memsizeM = 0; memunsignedM = 0; aluoutM = 0;
    writedataM = 0; writeregM = 0; regwriteM = 0; jumpM = 0; pcplus4M = 0;
    req_ready = 0; resp_valid = 0; resp_rdata = 0; tb_instr = 0;
  endtask

  task automatic run_instr(
    input string nm, input logic mw, input logic mr, input logic [1:0] sz, input logic uns,
    input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wr, input logic rw,
    input logic jp, input logic [31:0] pc4, input int rdy_wait, input int rsp_wait,
    input logic [31:0] rdata, input logic [31:0] exp_res, input logic exp_rw,
    input int exp_stall, input int exp_vcyc, input logic exp_mis, input logic exp_req,
    input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int c, wc, stalls, vc;
    logic accd, done;
    logic [68:0] first;
    memwriteM = mw; memtoregM = mr; memsizeM = sz; memunsignedM = uns; aluoutM = addr;
    writedataM = wd; writeregM = wr; regwriteM = rw; jumpM = jp; pcplus4M = pc4;
    tb_instr = 1;
    wbq.push_back('{exp_res, wr, exp_rw});
    if (exp_rw) wb_exp++;
    if (exp_req) rqq.push_back('{{addr[31:2], 2'b00}, exp_be, exp_wd, mw});
    c = 0; wc = 0; stalls = 0; vc = 0; accd = 0; done = 0; first = '0;
    while (!done && c < 50) begin
      req_ready  = (c >= rdy_wait);
      resp_valid = accd && (wc == rsp_wait);
      resp_rdata = resp_valid ? rdata : 32'd0;
      @(negedge clk);
      if (c == 0) chk({nm, "_misalign"}, {63'd0, misalignM}, {63'd0, exp_mis});
      if (stallM) stalls++;
      if (req_valid) begin
        vc++;
        if (vc == 1) first = {req_we, req_addr, req_be, req_wdata};
        else chk({nm, "_req_stable"}, {59'd0, req_we, req_addr, req_be, req_wdata}, {59'd0, first});
      end
      if (!stallM) done = 1;
      if (req_valid && req_ready) begin accd = 1; wc = 0; end
      else if (accd) wc++;
      @(posedge clk); #1;
      c++;
    end
    if (!done) chk({nm, "_timeout"}, 64'd0, 64'd1);
    chk({nm, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
    chk({nm, "_req_valid_cycles"}, 64'(vc), 64'(exp_vcyc));
    nop();
  endtask

  initial begin
    nop();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resultW", {32'd0, resultW}, 64'd0);
    chk("rst_writeregW", {59'd0, writeregW}, 64'd0);
    chk("rst_regwriteW", {63'd0, regwriteW}, 64'd0);
    chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_stallM", {63'd0, stallM}, 64'd0);
    reset = 0;
    @(posedge clk); #1;

    // name mw mr sz uns addr wd wr rw jp pc4 rdy rsp rdata | res rw stall vcyc mis req be wd
    run_instr("lw", 0, 1, 2'b10, 0, 32'h100, 0, 5'd3, 1, 0, 0, 0, 0, 32'hDEADBEEF,
              32'hDEADBEEF, 1, 1, 1, 0, 1, 4'b1111, 32'h0);
    run_instr("sb", 1, 0, 2'b00, 0, 32'h203, 32'h12345678, 5'd0, 0, 0, 0, 0, 0, 0,
              32'h203, 0, 1, 1, 0, 1, 4'b1000, 32'h78787878);
    run_instr("lb1", 0, 1, 2'b00, 0, 32'h401, 0, 5'd4, 1, 0, 0, 0, 0, 32'h80FF7F01,
              32'h0000007F, 1, 1, 1, 0, 1, 4'b0010, 32'h0);
    run_instr("lbu3", 0, 1, 2'b00, 1, 32'h403, 0, 5'd5, 1, 0, 0, 0, 0, 32'h80FF7F01,
              32'h00000080, 1, 1, 1, 0, 1, 4'b1000, 32'h0);
    run_instr("lh2", 0, 1, 2'b01, 0, 32'h402, 0, 5'd6, 1, 0, 0, 0, 0, 32'h80FF7F01,
              32'hFFFF80FF, 1, 1, 1, 0, 1, 4'b1100, 32'h0);
    run_instr("lhu2", 0, 1, 2'b01, 1, 32'h402, 0, 5'd7, 1, 0, 0, 0, 0, 32'h80FF7F01,
              32'h000080FF, 1, 1, 1, 0, 1, 4'b1100, 32'h0);
    run_instr("sh2", 1, 0, 2'b01, 0, 32'h502, 32'hAAAA1234, 5'd0, 0, 0, 0, 0, 0, 0,
              32'h502, 0, 1, 1, 0, 1, 4'b1100, 32'h12341234);
    run_instr("lw_bp", 0, 1, 2'b10, 0, 32'h600, 0, 5'd8, 1, 0, 0, 3, 2, 32'h01234567,
              32'h01234567, 1, 6, 4, 0, 1, 4'b1111, 32'h0);
    run_instr("sw_bp", 1, 0, 2'b10, 0, 32'h704, 32'hCAFEBABE, 5'd0, 0, 0, 0, 2, 1, 0,
              32'h704, 0, 4, 3, 0, 1, 4'b1111, 32'hCAFEBABE);
    run_instr("lw_mis", 0, 1, 2'b10, 0, 32'h102, 0, 5'd9, 1, 0, 0, 0, 0, 0,
              32'h0, 0, 0, 0, 1, 0, 4'b0000, 32'h0);
    run_instr("lh_mis", 0, 1, 2'b01, 0, 32'h103, 0, 5'd10, 1, 0, 0, 0, 0, 0,
              32'h0, 0, 0, 0, 1, 0, 4'b0000, 32'h0);
    run_instr("alu", 0, 0, 2'b00, 0, 32'h55AA1234, 0, 5'd11, 1, 0, 0, 0, 0, 0,
              32'h55AA1234, 1, 0, 0, 0, 0, 4'b0000, 32'h0);

    // Reset in the middle of an access, then a stray response after release.
    memtoregM = 1; memsizeM = 2'b10; aluoutM = 32'h300; writeregM = 5'd12; regwriteM = 1;
    req_ready = 1;
    rqq.push_back('{32'h300, 4'b1111, 32'h0, 1'b0});
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait_req_valid", {63'd0, req_valid}, 64'd0);
    chk("wait_stallM", {63'd0, stallM}, 64'd1);
    #2 reset = 1;
    #1;
    chk("midrst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("midrst_regwriteW", {63'd0, regwriteW}, 64'd0);
    chk("midrst_resultW", {32'd0, resultW}, 64'd0);
    nop();
    @(posedge clk); #1;
    reset = 0;
    resp_valid = 1; resp_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("late_resp_stallM", {63'd0, stallM}, 64'd0);
    chk("late_resp_req_valid", {63'd0, req_valid}, 64'd0);
    @(posedge clk); #1;
    resp_valid = 0; resp_rdata = 0;
    @(negedge clk);
    chk("late_resp_regwriteW", {63'd0, regwriteW}, 64'd0);
    chk("late_resp_resultW", {32'd0, resultW}, 64'd0);
    @(posedge clk); #1;

    run_instr("jal", 0, 0, 2'b00, 0, 32'h0000BEEF, 0, 5'd31, 1, 1, 32'h1004, 0, 0, 0,
              32'h1004, 1, 0, 0, 0, 0, 4'b0000, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("wb_queue_empty", 64'(wbq.size()), 64'd0);
    chk("req_queue_empty", 64'(rqq.size()), 64'd0);
    chk("wb_write_count", 64'(wb_seen), 64'(wb_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
